// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and its PLL / system-reset consumers.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_reset_req;
  logic       pll_rst;
  logic       sys_reset_0;
  logic       sys_reset_1;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  // Environment side: drives PLL status and software requests, observes resets.
  modport master (
    output locked,
    output pll_reset_req,
    input  pll_rst,
    input  sys_reset_0,
    input  sys_reset_1,
    input  ready,
    input  relock_count,
    input  timeout_err
  );

  // Sequencer side.
  modport slave (
    input  locked,
    input  pll_reset_req,
    output pll_rst,
    output sys_reset_0,
    output sys_reset_1,
    output ready,
    output relock_count,
    output timeout_err
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a continuously stable lock,
// then releases sys_reset_0 and, after a gap, sys_reset_1. Re-sequences on lock
// loss, lock timeout or a software request.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP        = 8
) (
  input logic                  clk,
  input logic                  reset,
  pll_reset_sequencer_if.slave bus
);

  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sync_q1;
  logic             locked_s;
  logic             lock_loss;
  logic             timeout_hit;

  logic             pll_rst_q;
  logic             sys_reset_0_q;
  logic             sys_reset_1_q;
  logic             ready_q;
  logic [7:0]       relock_q;
  logic             timeout_err_q;

  logic             pll_rst_d;
  logic             sys_reset_0_d;
  logic             sys_reset_1_d;
  logic             ready_d;
  logic [7:0]       relock_d;
  logic             timeout_err_d;

  // Two-flop synchronizer for the asynchronous PLL locked indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= bus.locked;
      locked_s <= sync_q1;
    end
  end

  // State, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_PLL_RST;
      cnt           <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_0_q <= 1'b1;
      sys_reset_1_q <= 1'b1;
      ready_q       <= 1'b0;
      relock_q      <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pll_rst_q     <= pll_rst_d;
      sys_reset_0_q <= sys_reset_0_d;
      sys_reset_1_q <= sys_reset_1_d;
      ready_q       <= ready_d;
      relock_q      <= relock_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state, counter and next-output decode; a software request outranks everything.
  always_comb begin
    state_nxt     = state;
    lock_loss     = 1'b0;
    timeout_hit   = 1'b0;
    cnt_nxt       = cnt;
    pll_rst_d     = 1'b1;
    sys_reset_0_d = 1'b1;
    sys_reset_1_d = 1'b1;
    ready_d       = 1'b0;
    relock_d      = relock_q;
    timeout_err_d = timeout_err_q;

    if (bus.pll_reset_req) begin
      state_nxt = S_PLL_RST;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == PLL_RST_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = S_PLL_RST;
          end
        end
        S_STABLE: begin
          if (!locked_s)                state_nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_nxt = S_RELEASE;
        end
        S_RELEASE: begin
          if (!locked_s) begin
            lock_loss = 1'b1;
            state_nxt = S_WAIT_LOCK;
          end else if (cnt == GAP_LAST) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            lock_loss = 1'b1;
            state_nxt = S_WAIT_LOCK;
          end
        end
        default: state_nxt = S_PLL_RST;
      endcase
    end

    // Counter restarts on any transition (including a request re-entering PLL_RST).
    if (bus.pll_reset_req || (state_nxt != state)) cnt_nxt = '0;
    else if (state != S_RUN)                        cnt_nxt = cnt + CNT_W'(1);

    if (lock_loss && (relock_q != 8'hFF)) relock_d = relock_q + 8'd1;
    if (timeout_hit)                      timeout_err_d = 1'b1;

    pll_rst_d     = (state_nxt == S_PLL_RST);
    sys_reset_0_d = !((state_nxt == S_RELEASE) || (state_nxt == S_RUN));
    sys_reset_1_d = (state_nxt != S_RUN);
    ready_d       = (state_nxt == S_RUN);
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_reset_0  = sys_reset_0_q;
  assign bus.sys_reset_1  = sys_reset_1_q;
  assign bus.ready        = ready_q;
  assign bus.relock_count = relock_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized and directed bench for pll_reset_sequencer against a phase/age reference model.
module tb_pll_reset_sequencer;

  localparam int unsigned P_RST    = 4;
  localparam int unsigned P_TMO    = 20;
  localparam int unsigned P_STABLE = 8;
  localparam int unsigned P_GAP    = 3;

  typedef enum int {M_PLLRST, M_WAIT, M_STABLE, M_RELEASE, M_RUN} mphase_t;

  logic clk;
  logic reset;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT      (P_TMO),
    .LOCK_STABLE_CYCLES(P_STABLE),
    .RELEASE_GAP       (P_GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc      = 0;

  // Reference model: phase, edge of phase entry, delayed view of locked, counters.
  mphase_t m_phase  = M_PLLRST;
  int      m_entry  = 0;
  int      m_relock = 0;
  logic    m_terr   = 1'b0;
  logic    m_d1     = 1'b0;
  logic    m_d2     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic enter(input mphase_t p);
    m_phase = p;
    m_entry = cyc;
  endtask

  task automatic lose_lock();
    if (m_relock < 255) m_relock++;
    enter(M_WAIT);
  endtask

  // One edge of the model: locked is seen two edges after it is sampled; each
  // phase lasts its configured number of edges measured from its entry edge.
  task automatic model_edge(input logic rst_i, input logic lk_i, input logic req_i);
    logic ls;
    int   age;
    if (rst_i) begin
      enter(M_PLLRST);
      m_relock = 0;
      m_terr   = 1'b0;
      m_d1     = 1'b0;
      m_d2     = 1'b0;
      return;
    end
    ls   = m_d2;
    age  = cyc - m_entry;
    m_d2 = m_d1;
    m_d1 = lk_i;
    if (req_i) begin
      enter(M_PLLRST);
    end else begin
      case (m_phase)
        M_PLLRST:  if (age == P_RST) enter(M_WAIT);
        M_WAIT: begin
          if (ls) enter(M_STABLE);
          else if (age == P_TMO) begin
            m_terr = 1'b1;
            enter(M_PLLRST);
          end
        end
        M_STABLE: begin
          if (!ls) enter(M_WAIT);
          else if (age == P_STABLE) enter(M_RELEASE);
        end
        M_RELEASE: begin
          if (!ls) lose_lock();
          else if (age == P_GAP) enter(M_RUN);
        end
        M_RUN:     if (!ls) lose_lock();
        default:   enter(M_PLLRST);
      endcase
    end
  endtask

  task automatic compare_all();
    check("pll_rst",      bus.pll_rst,      32'(m_phase == M_PLLRST));
    check("sys_reset_0",  bus.sys_reset_0,  32'(!(m_phase == M_RELEASE || m_phase == M_RUN)));
    check("sys_reset_1",  bus.sys_reset_1,  32'(m_phase != M_RUN));
    check("ready",        bus.ready,        32'(m_phase == M_RUN));
    check("relock_count", bus.relock_count, 32'(m_relock));
    check("timeout_err",  bus.timeout_err,  32'(m_terr));
  endtask

  // Drive inputs for the next edge, clock it, advance the model, compare after the edge.
  task automatic step(input logic rst_i, input logic lk_i, input logic req_i);
    reset             = rst_i;
    bus.locked        = lk_i;
    bus.pll_reset_req = req_i;
    @(posedge clk);
    cyc++;
    model_edge(rst_i, lk_i, req_i);
    #1;
    compare_all();
  endtask

  task automatic run_until(input mphase_t tgt, input int budget, input string tag);
    int n;
    n = 0;
    while (m_phase != tgt && n < budget) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    check(tag, 32'(m_phase == tgt), 32'd1);
  endtask

  initial begin
    int saved;
    int pcnt;
    int lock_cnt;
    logic lk;
    logic rq;
    logic rs;

    reset             = 1'b1;
    bus.locked        = 1'b0;
    bus.pll_reset_req = 1'b0;
    repeat (2) @(posedge clk);

    // Basic lock: edge 0 is the reset edge; locked sampled high from edge 10.
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, (k >= 10), 1'b0);
      if (k == 3)  check("t1_pll_rst_e3", bus.pll_rst, 32'd1);
      if (k == 4)  check("t1_pll_rst_e4", bus.pll_rst, 32'd0);
      if (k == 19) check("t1_sr0_e19", bus.sys_reset_0, 32'd1);
      if (k == 20) check("t1_sr0_e20", bus.sys_reset_0, 32'd0);
      if (k == 22) check("t1_ready_e22", bus.ready, 32'd0);
      if (k == 23) begin
        check("t1_sr1_e23", bus.sys_reset_1, 32'd0);
        check("t1_ready_e23", bus.ready, 32'd1);
        check("t1_relock", bus.relock_count, 32'd0);
      end
    end

    // Never locks: repeated PLL reset pulses, sticky timeout.
    for (int k = 0; k < 80; k++) step(1'b0, 1'b0, 1'b0);
    check("t2_timeout_err", bus.timeout_err, 32'd1);
    check("t2_sr0_held", bus.sys_reset_0, 32'd1);

    // Single-cycle glitch while in STABLE.
    run_until(M_STABLE, 60, "t3_reach_stable");
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_until(M_RUN, 60, "t3_reach_run");

    // Loss in RUN: outputs react two edges after the drop is sampled.
    saved = m_relock;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("t4_ready_hold", bus.ready, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("t4_ready_drop", bus.ready, 32'd0);
    check("t4_sr0_drop", bus.sys_reset_0, 32'd1);
    check("t4_relock_inc", bus.relock_count, 32'(saved + 1));
    for (int i = 0; i < 300; i++) begin
      run_until(M_RUN, 40, "t4_relock_run");
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    check("t4_relock_sat", bus.relock_count, 32'd255);

    // Request and lock loss on the same edge in RUN.
    run_until(M_RUN, 40, "t5_reach_run");
    saved = int'(bus.relock_count);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("t5_relock_same", bus.relock_count, 32'(saved));
    pcnt = int'(bus.pll_rst);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0);
      pcnt += int'(bus.pll_rst);
    end
    check("t5_pll_rst_len", 32'(pcnt), 32'd4);

    // Reset one cycle after sys_reset_0 falls.
    run_until(M_RELEASE, 60, "t6_reach_release");
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_sr0", bus.sys_reset_0, 32'd1);
    check("t6_pll_rst", bus.pll_rst, 32'd1);
    check("t6_relock", bus.relock_count, 32'd0);
    check("t6_timeout_err", bus.timeout_err, 32'd0);
    run_until(M_RUN, 60, "t6_reach_run");

    // Random PLL behaviour: variable lock delay, sparse glitches, requests and resets.
    lock_cnt = 0;
    for (int k = 0; k < 5000; k++) begin
      if (m_phase == M_PLLRST) begin
        lock_cnt = int'($urandom_range(1, 26));
        lk = 1'b0;
      end else if (lock_cnt > 0) begin
        lock_cnt--;
        lk = 1'b0;
      end else begin
        lk = ($urandom_range(0, 49) != 0);
      end
      rq = ($urandom_range(0, 199) == 0);
      rs = ($urandom_range(0, 799) == 0);
      step(rs, lk, rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
